// File: rtl/flag_pipe.sv
// Pipelined zero/NZCV flag unit: registered RADIX-ary OR tree over the ALU result,
// with N/C/V riding along and a committed architectural {N,Z,C,V} register.
module flag_pipe #(
  parameter int WIDTH = 64,
  parameter int RADIX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  output logic             z_out,
  output logic [3:0]       flags,
  output logic             flags_busy
);

  function automatic int calc_depth(input int w, input int r);
    int n;
    int d;
    n = w;
    d = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = (n + r - 1) / r;
        d = d + 1;
      end
    end
    return d;
  endfunction

  localparam int D  = calc_depth(WIDTH, RADIX);
  localparam int NG = (WIDTH + RADIX - 1) / RADIX;
  localparam int PW = NG * RADIX;

  // Every level is held at the level-1 width; bits past a level's real width stay zero,
  // so the same grouping logic serves all levels and stage D carries any_one in bit 0.
  logic [D-1:0][NG-1:0] r_lvl;
  logic [D-1:0]         r_vld;
  logic [D-1:0]         r_sf;
  logic [D-1:0]         r_n;
  logic [D-1:0]         r_c;
  logic [D-1:0]         r_v;
  logic [3:0]           r_flags;

  logic [D-1:0][PW-1:0] w_pad;
  logic [D-1:0][NG-1:0] w_or;
  logic                 w_any;

  always_comb begin
    w_pad = '0;
    w_or  = '0;
    w_pad[0][WIDTH-1:0] = result;
    for (int s = 1; s < D; s++) begin
      w_pad[s][NG-1:0] = r_lvl[s-1];
    end
    for (int s = 0; s < D; s++) begin
      for (int g = 0; g < NG; g++) begin
        w_or[s][g] = |w_pad[s][g*RADIX +: RADIX];
      end
    end
  end

  assign w_any = |r_lvl[D-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lvl   <= '0;
      r_vld   <= '0;
      r_sf    <= '0;
      r_n     <= '0;
      r_c     <= '0;
      r_v     <= '0;
      r_flags <= '0;
    end else begin
      // The stage-D op commits even on a flush edge: it has already left the pipe.
      if (r_vld[D-1] && r_sf[D-1]) begin
        r_flags <= {r_n[D-1], ~w_any, r_c[D-1], r_v[D-1]};
      end
      r_lvl[0] <= w_or[0];
      r_vld[0] <= in_valid & ~flush;
      r_sf[0]  <= set_flags;
      r_n[0]   <= result[WIDTH-1];
      r_c[0]   <= carry_in;
      r_v[0]   <= ovf_in;
      for (int s = 1; s < D; s++) begin
        r_lvl[s] <= w_or[s];
        r_vld[s] <= r_vld[s-1] & ~flush;
        r_sf[s]  <= r_sf[s-1];
        r_n[s]   <= r_n[s-1];
        r_c[s]   <= r_c[s-1];
        r_v[s]   <= r_v[s-1];
      end
    end
  end

  assign out_valid  = r_vld[D-1];
  assign z_out      = r_vld[D-1] & ~w_any;
  assign flags      = r_flags;
  assign flags_busy = |(r_vld & r_sf);

endmodule

// File: tb/tb_flag_pipe.sv
// Directed bench for flag_pipe (WIDTH=64, RADIX=4, D=3) with a latency-queue scoreboard.
module tb_flag_pipe;

  localparam int W = 64;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] result = '0;
  logic         carry_in = 1'b0;
  logic         ovf_in = 1'b0;
  logic         set_flags = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         z_out;
  logic [3:0]   flags;
  logic         flags_busy;

  flag_pipe #(.WIDTH(W), .RADIX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .result     (result),
    .carry_in   (carry_in),
    .ovf_in     (ovf_in),
    .set_flags  (set_flags),
    .flush      (flush),
    .out_valid  (out_valid),
    .z_out      (z_out),
    .flags      (flags),
    .flags_busy (flags_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       sf;
    logic       z;
    logic [3:0] nzcv;
  } ent_t;

  ent_t       q[$];
  logic [3:0] exp_flags;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ent_t e;
    e.v = 1'b0; e.sf = 1'b0; e.z = 1'b0; e.nzcv = 4'b0000;
    q.delete();
    for (int i = 0; i < D; i++) q.push_back(e);
    exp_flags = 4'b0000;
  endtask

  task automatic check_outputs(input string tag);
    logic busy;
    busy = 1'b0;
    foreach (q[i]) busy = busy | (q[i].v & q[i].sf);
    chk({tag, ".out_valid"},  {3'b000, out_valid},  {3'b000, q[0].v});
    chk({tag, ".z_out"},      {3'b000, z_out},      {3'b000, q[0].v & q[0].z});
    chk({tag, ".flags"},      flags,                exp_flags);
    chk({tag, ".flags_busy"}, {3'b000, flags_busy}, {3'b000, busy});
  endtask

  // Drives one cycle of stimulus, advances the scoreboard across the edge, then checks.
  task automatic step(input string tag, input logic v, input logic [W-1:0] res,
                      input logic c, input logic ov, input logic sf, input logic fl);
    ent_t e;
    in_valid  = v;
    result    = res;
    carry_in  = c;
    ovf_in    = ov;
    set_flags = sf;
    flush     = fl;
    e.v    = v & ~fl;
    e.sf   = sf;
    e.z    = (res == '0);
    e.nzcv = {res[W-1], (res == '0), c, ov};
    @(posedge clk);
    if (q[0].v && q[0].sf) exp_flags = q[0].nzcv;
    void'(q.pop_front());
    if (fl) foreach (q[i]) q[i].v = 1'b0;
    q.push_back(e);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    chk({tag, ".rst_out_valid"},  {3'b000, out_valid},  4'b0000);
    chk({tag, ".rst_z_out"},      {3'b000, z_out},      4'b0000);
    chk({tag, ".rst_flags"},      flags,                4'b0000);
    chk({tag, ".rst_flags_busy"}, {3'b000, flags_busy}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs({tag, ".post"});
  endtask

  initial begin
    logic [W-1:0] r;
    logic         sf;

    model_clear();
    async_reset("init");

    // zero result, C=1: Z visible after edge 2, flags 0110 after edge 3
    step("t1.e0", 1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t1.e1", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t1.e2", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.zero_out", {2'b00, out_valid, z_out}, 4'b0011);
    step("t1.e3", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.flags_lit", flags, 4'b0110);

    // back-to-back commits: last one wins, in order
    step("t2.a", 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t2.b", 1'b1, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t2.c", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t2.d", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.flags0", flags, 4'b0100);
    step("t2.e", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.flags1", flags, 4'b0000);
    step("t2.f", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.flags2", flags, 4'b1000);

    // non-flag-setting op leaves flags alone
    step("t3.set", 1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("t3.drain", D);
    chk("t3.flags_pre", flags, 4'b0100);
    step("t3.op", 1'b1, 64'd497403948, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("t3.run", D + 1);
    chk("t3.flags_post", flags, 4'b0100);

    // flush at edge 1 kills the op; op presented with flush is dropped
    step("t4.issue", 1'b1, 64'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4.busy1", {3'b000, flags_busy}, 4'b0001);
    step("t4.flush", 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4.busy0", {3'b000, flags_busy}, 4'b0000);
    idle("t4.after", D + 1);
    chk("t4.flags", flags, 4'b0100);

    // async reset with three ops in flight; nothing commits afterwards
    step("t5.a", 1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("t5.b", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t5.c", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    async_reset("t5");
    idle("t5.after", D + 1);

    // boundary values: all-ones and bit 0 only
    step("t6.ones", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    step("t6.bit0", 1'b1, 64'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("t6.drain", D);

    // single-bit sweep plus zero, random set_flags/C/V, back to back
    for (int i = 0; i <= W; i++) begin
      r  = (i < W) ? (64'h1 << i) : 64'h0;
      sf = 1'($urandom_range(0, 1));
      step("t7.sweep", 1'b1, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sf, 1'b0);
    end
    idle("t7.drain", D + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
